// File: rtl/tx_window_ctrl.sv
// Transmit-window controller: a synchronised start edge opens a tx_enable window
// of window_len prescaled ticks, with retrigger/periodic modes, hold-off and abort.
module tx_window_ctrl #(
   parameter int TICK_DIV      = 4800000,
   parameter int CNT_W         = 14,
   parameter int HOLDOFF_TICKS = 0,
   parameter int SYNC_STAGES   = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [1:0]       mode,
   input  logic [CNT_W-1:0] window_len,
   output logic             tx_enable,
   output logic             busy,
   output logic [CNT_W-1:0] remaining,
   output logic             done
);

   localparam int PW = $clog2(TICK_DIV);
   localparam int HW = (HOLDOFF_TICKS > 1) ? $clog2(HOLDOFF_TICKS + 1) : 1;
   localparam logic [PW-1:0] PRE_MAX   = PW'(TICK_DIV - 1);
   localparam logic [HW-1:0] HOLD_INIT = HW'(HOLDOFF_TICKS);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACTIVE = 2'd1;
   localparam logic [1:0] S_HOLD   = 2'd2;

   localparam logic [1:0] M_RETRIG   = 2'b01;
   localparam logic [1:0] M_PERIODIC = 2'b10;

   logic [SYNC_STAGES-1:0] sync_q, fill_q;
   logic                   edge_q, armed_q, req_q;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [PW-1:0]    pre_q, pre_d;
   logic [HW-1:0]    hold_q, hold_d;
   logic [1:0]       mode_q, mode_d;
   logic             per_q, per_d;
   logic             done_d, tx_q, done_q;
   logic             tick_w, launch, close;

   // fill_q marks when the synchroniser output reflects a real sample of start;
   // armed_q then requires a low level first, so a start held across reset is ignored.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q  <= '0;
         fill_q  <= '0;
         edge_q  <= 1'b0;
         armed_q <= 1'b0;
         req_q   <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], start};
         fill_q  <= {fill_q[SYNC_STAGES-2:0], 1'b1};
         edge_q  <= sync_q[SYNC_STAGES-1];
         armed_q <= armed_q | (fill_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES-1]);
         req_q   <= armed_q & sync_q[SYNC_STAGES-1] & ~edge_q;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pre_d   = pre_q;
      hold_d  = hold_q;
      mode_d  = mode_q;
      per_d   = per_q;
      done_d  = 1'b0;
      launch  = 1'b0;
      close   = 1'b0;
      tick_w  = (pre_q == PRE_MAX);

      case (state_q)
         S_IDLE: begin
            // per_q can only be set here when there is no hold-off: it is the
            // one-cycle gap between periodic windows.
            if (abort) per_d = 1'b0;
            else if (req_q || per_q) begin
               if (window_len != '0) launch = 1'b1;
               else                  per_d  = 1'b0;
            end
         end
         S_ACTIVE: begin
            pre_d = tick_w ? '0 : pre_q + 1'b1;
            if (abort) begin
               per_d = 1'b0;
               close = 1'b1;
            end else if (req_q && mode_q == M_RETRIG && window_len != '0) begin
               cnt_d = window_len;
               pre_d = '0;
            end else if (tick_w && cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == CNT_W'(1)) begin
                  done_d = 1'b1;
                  close  = 1'b1;
               end
            end
         end
         S_HOLD: begin
            pre_d = tick_w ? '0 : pre_q + 1'b1;
            if (abort) per_d = 1'b0;
            if (tick_w) begin
               hold_d = hold_q - 1'b1;
               if (hold_q == HW'(1)) begin
                  if (per_q && !abort && window_len != '0) launch = 1'b1;
                  else begin
                     state_d = S_IDLE;
                     per_d   = 1'b0;
                  end
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (close) begin
         pre_d = '0;
         if (HOLDOFF_TICKS == 0) state_d = S_IDLE;
         else begin
            state_d = S_HOLD;
            hold_d  = HOLD_INIT;
         end
      end
      if (launch) begin
         state_d = S_ACTIVE;
         cnt_d   = window_len;
         mode_d  = mode;
         pre_d   = '0;
         per_d   = (mode == M_PERIODIC);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         pre_q   <= '0;
         hold_q  <= '0;
         mode_q  <= '0;
         per_q   <= 1'b0;
         tx_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pre_q   <= pre_d;
         hold_q  <= hold_d;
         mode_q  <= mode_d;
         per_q   <= per_d;
         tx_q    <= (state_d == S_ACTIVE);
         done_q  <= done_d;
      end
   end

   assign tx_enable = tx_q;
   assign done      = done_q;
   assign busy      = (state_q != S_IDLE);
   assign remaining = (state_q == S_ACTIVE) ? cnt_q : '0;

endmodule

// File: tb/tb_tx_window_ctrl.sv
// Bench for tx_window_ctrl: expected windows are queued when start is driven and
// matched against windows the monitor observes on tx_enable.
module tb_tx_window_ctrl;
   localparam int TD = 4, HT = 2, SS = 2, CW = 14;

   logic          clk = 1'b0, reset = 1'b0, start = 1'b0, abort = 1'b0;
   logic [1:0]    mode = 2'b00;
   logic [CW-1:0] window_len = '0;
   logic          tx_enable, busy, done;
   logic [CW-1:0] remaining;

   typedef struct {int hi; bit dn;} win_t;
   win_t exp_q[$], obs_q[$];
   int   n_chk = 0, n_fail = 0, done_cnt = 0, hi_cnt = 0;
   bit   tx_prev = 1'b0;

   always #5 clk = ~clk;

   tx_window_ctrl #(.TICK_DIV(TD), .CNT_W(CW), .HOLDOFF_TICKS(HT), .SYNC_STAGES(SS)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .mode(mode),
      .window_len(window_len), .tx_enable(tx_enable), .busy(busy),
      .remaining(remaining), .done(done));

   // Window monitor: records high length and whether done accompanies the fall.
   always @(negedge clk) begin
      if (!reset) begin
         hi_cnt  = 0;
         tx_prev = 1'b0;
      end else begin
         if (done) done_cnt++;
         if (tx_enable) hi_cnt++;
         else if (tx_prev) begin
            obs_q.push_back('{hi: hi_cnt, dn: done});
            hi_cnt = 0;
         end
         tx_prev = tx_enable;
      end
   end

   task tick();
      @(posedge clk); #1;
   endtask

   task automatic wait_obs(output bit got);
      for (int i = 0; i < 400 && obs_q.size() == 0; i++) tick();
      got = (obs_q.size() != 0);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 200 && busy; i++) tick();
   endtask

   task automatic test_reset();
      #2;
      n_chk++;
      if ({tx_enable, busy, done, remaining} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got tx=%b busy=%b done=%b rem=%0d, want all 0",
                  tx_enable, busy, done, remaining);
      end
      tick(); tick();
      reset = 1'b1;
      repeat (5) tick();
   endtask

   task automatic test_oneshot();
      int d0, b; bit got; win_t o, e;
      d0 = done_cnt; mode = 2'b00; window_len = 3;
      exp_q.push_back('{hi: 12, dn: 1'b1});
      start = 1'b1; tick(); start = 1'b0;
      tick(); tick();
      n_chk++;
      if (tx_enable !== 1'b0) begin n_fail++; $display("FAIL oneshot_early: tx=%b want 0", tx_enable); end
      tick();
      n_chk++;
      if ({tx_enable, busy, remaining} !== {1'b1, 1'b1, 14'd3}) begin
         n_fail++; $display("FAIL oneshot_rise: tx=%b busy=%b rem=%0d want 1 1 3", tx_enable, busy, remaining);
      end
      repeat (12) tick();
      n_chk++;
      if ({tx_enable, done, busy} !== 3'b011) begin
         n_fail++; $display("FAIL oneshot_fall: tx/done/busy=%b want 011", {tx_enable, done, busy});
      end
      b = 0;
      for (int i = 0; i < 20; i++) begin if (busy) b++; tick(); end
      n_chk++;
      if (b != 8) begin n_fail++; $display("FAIL oneshot_holdoff: busy cycles=%0d want 8", b); end
      wait_obs(got);
      n_chk++;
      if (!got) begin n_fail++; $display("FAIL oneshot_window: no window seen, want 1"); end
      else begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         if (o.hi != e.hi || o.dn != e.dn) begin
            n_fail++; $display("FAIL oneshot_window: hi=%0d done=%b want hi=%0d done=%b", o.hi, o.dn, e.hi, e.dn);
         end
      end
      n_chk++;
      if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL oneshot_done: pulses=%0d want 1", done_cnt - d0); end
   endtask

   task automatic test_retrigger();
      int d0; bit got; win_t o, e;
      d0 = done_cnt; mode = 2'b01; window_len = 5;
      exp_q.push_back('{hi: 32, dn: 1'b1});
      start = 1'b1; tick(); start = 1'b0;
      repeat (11) tick();
      start = 1'b1; tick(); start = 1'b0;
      tick(); tick();
      n_chk++;
      if (remaining !== 14'd3) begin n_fail++; $display("FAIL retrig_before: rem=%0d want 3", remaining); end
      tick();
      n_chk++;
      if ({tx_enable, remaining} !== {1'b1, 14'd5}) begin
         n_fail++; $display("FAIL retrig_reload: tx=%b rem=%0d want 1 5", tx_enable, remaining);
      end
      wait_obs(got);
      n_chk++;
      if (!got) begin n_fail++; $display("FAIL retrig_window: no window seen, want 1"); end
      else begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         if (o.hi != e.hi || o.dn != e.dn) begin
            n_fail++; $display("FAIL retrig_window: hi=%0d done=%b want hi=%0d done=%b", o.hi, o.dn, e.hi, e.dn);
         end
      end
      wait_idle();
      n_chk++;
      if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL retrig_done: pulses=%0d want 1", done_cnt - d0); end
   endtask

   task automatic test_periodic_abort();
      int d0, h; bit got; win_t o, e;
      d0 = done_cnt; mode = 2'b10; window_len = 2;
      exp_q.push_back('{hi: 8, dn: 1'b1});
      exp_q.push_back('{hi: 8, dn: 1'b1});
      exp_q.push_back('{hi: 3, dn: 1'b0});
      start = 1'b1; tick(); start = 1'b0;
      repeat (11) tick();
      n_chk++;
      if ({tx_enable, done, busy} !== 3'b011) begin
         n_fail++; $display("FAIL periodic_gap: tx/done/busy=%b want 011", {tx_enable, done, busy});
      end
      repeat (7) tick();
      n_chk++;
      if (tx_enable !== 1'b0) begin n_fail++; $display("FAIL periodic_gap_end: tx=%b want 0", tx_enable); end
      tick();
      n_chk++;
      if (tx_enable !== 1'b1) begin n_fail++; $display("FAIL periodic_second: tx=%b want 1", tx_enable); end
      repeat (18) tick();
      abort = 1'b1; tick(); abort = 1'b0; mode = 2'b00;
      n_chk++;
      if ({tx_enable, done, busy} !== 3'b001) begin
         n_fail++; $display("FAIL periodic_abort: tx/done/busy=%b want 001", {tx_enable, done, busy});
      end
      h = 0;
      for (int i = 0; i < 60; i++) begin if (tx_enable) h++; tick(); end
      n_chk++;
      if (h != 0) begin n_fail++; $display("FAIL periodic_no_fourth: tx high %0d cycles want 0", h); end
      for (int k = 0; k < 3; k++) begin
         wait_obs(got);
         n_chk++;
         if (!got) begin n_fail++; $display("FAIL periodic_window%0d: no window seen", k); end
         else begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            if (o.hi != e.hi || o.dn != e.dn) begin
               n_fail++; $display("FAIL periodic_window%0d: hi=%0d done=%b want hi=%0d done=%b",
                                  k, o.hi, o.dn, e.hi, e.dn);
            end
         end
      end
      n_chk++;
      if (done_cnt - d0 != 2) begin n_fail++; $display("FAIL periodic_done: pulses=%0d want 2", done_cnt - d0); end
   endtask

   task automatic test_ignored();
      int b; bit got; win_t o, e;
      mode = 2'b00; window_len = 0;
      start = 1'b1; tick(); start = 1'b0;
      b = 0;
      for (int i = 0; i < 15; i++) begin if (busy || tx_enable) b++; tick(); end
      n_chk++;
      if (b != 0) begin n_fail++; $display("FAIL ignore_len0: active %0d cycles want 0", b); end

      window_len = 2;
      exp_q.push_back('{hi: 8, dn: 1'b1});
      start = 1'b1; tick(); start = 1'b0;
      repeat (11) tick();
      n_chk++;
      if ({tx_enable, busy} !== 2'b01) begin
         n_fail++; $display("FAIL ignore_in_holdoff_state: tx/busy=%b want 01", {tx_enable, busy});
      end
      start = 1'b1; tick(); start = 1'b0;
      b = 0;
      for (int i = 0; i < 40; i++) begin if (tx_enable) b++; tick(); end
      n_chk++;
      if (b != 0) begin n_fail++; $display("FAIL ignore_holdoff_req: tx high %0d cycles want 0", b); end
      wait_obs(got);
      n_chk++;
      if (!got) begin n_fail++; $display("FAIL ignore_window: no window seen, want 1"); end
      else begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         if (o.hi != e.hi || o.dn != e.dn || obs_q.size() != 0) begin
            n_fail++; $display("FAIL ignore_window: hi=%0d done=%b extra=%0d want hi=%0d done=%b extra=0",
                               o.hi, o.dn, obs_q.size(), e.hi, e.dn);
         end
      end

      abort = 1'b1;
      start = 1'b1; tick(); start = 1'b0;
      repeat (6) tick();
      abort = 1'b0;
      b = 0;
      for (int i = 0; i < 20; i++) begin if (busy || tx_enable) b++; tick(); end
      n_chk++;
      if (b != 0 || obs_q.size() != 0) begin
         n_fail++; $display("FAIL ignore_abort_req: active %0d windows %0d want 0 0", b, obs_q.size());
      end
   endtask

   task automatic test_collision();
      int d0; bit got; win_t o, e;
      d0 = done_cnt; mode = 2'b01; window_len = 1;
      exp_q.push_back('{hi: 8, dn: 1'b1});
      start = 1'b1; tick(); start = 1'b0;
      repeat (3) tick();
      start = 1'b1; tick(); start = 1'b0;
      repeat (3) tick();
      n_chk++;
      if ({tx_enable, done} !== 2'b10) begin
         n_fail++; $display("FAIL retrig_vs_expiry: tx/done=%b want 10", {tx_enable, done});
      end
      wait_obs(got);
      n_chk++;
      if (!got) begin n_fail++; $display("FAIL retrig_vs_expiry_window: no window seen"); end
      else begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         if (o.hi != e.hi || o.dn != e.dn) begin
            n_fail++; $display("FAIL retrig_vs_expiry_window: hi=%0d done=%b want hi=%0d done=%b", o.hi, o.dn, e.hi, e.dn);
         end
      end
      wait_idle();

      d0 = done_cnt; mode = 2'b00;
      exp_q.push_back('{hi: 4, dn: 1'b0});
      start = 1'b1; tick(); start = 1'b0;
      repeat (6) tick();
      abort = 1'b1; tick(); abort = 1'b0;
      n_chk++;
      if ({tx_enable, done, busy} !== 3'b001) begin
         n_fail++; $display("FAIL abort_vs_expiry: tx/done/busy=%b want 001", {tx_enable, done, busy});
      end
      wait_obs(got);
      n_chk++;
      if (!got) begin n_fail++; $display("FAIL abort_vs_expiry_window: no window seen"); end
      else begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         if (o.hi != e.hi || o.dn != e.dn) begin
            n_fail++; $display("FAIL abort_vs_expiry_window: hi=%0d done=%b want hi=%0d done=%b", o.hi, o.dn, e.hi, e.dn);
         end
      end
      wait_idle();
      n_chk++;
      if (done_cnt - d0 != 0) begin n_fail++; $display("FAIL abort_vs_expiry_done: pulses=%0d want 0", done_cnt - d0); end
   endtask

   task automatic test_reset_mid();
      int b; bit got; win_t o, e;
      mode = 2'b00; window_len = 10;
      start = 1'b1;
      repeat (6) tick();
      reset = 1'b0; #1;
      n_chk++;
      if ({tx_enable, busy, done, remaining} !== '0) begin
         n_fail++; $display("FAIL reset_mid_outputs: tx=%b busy=%b done=%b rem=%0d want all 0",
                            tx_enable, busy, done, remaining);
      end
      tick(); tick();
      reset = 1'b1;
      b = 0;
      for (int i = 0; i < 15; i++) begin if (busy || tx_enable) b++; tick(); end
      n_chk++;
      if (b != 0) begin n_fail++; $display("FAIL reset_held_start: active %0d cycles want 0", b); end
      start = 1'b0;
      repeat (4) tick();
      exp_q.push_back('{hi: 40, dn: 1'b1});
      start = 1'b1; tick();
      tick(); tick();
      n_chk++;
      if (tx_enable !== 1'b0) begin n_fail++; $display("FAIL reset_fresh_early: tx=%b want 0", tx_enable); end
      tick();
      n_chk++;
      if (tx_enable !== 1'b1) begin n_fail++; $display("FAIL reset_fresh_rise: tx=%b want 1", tx_enable); end
      start = 1'b0;
      wait_obs(got);
      n_chk++;
      if (!got) begin n_fail++; $display("FAIL reset_fresh_window: no window seen"); end
      else begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         if (o.hi != e.hi || o.dn != e.dn) begin
            n_fail++; $display("FAIL reset_fresh_window: hi=%0d done=%b want hi=%0d done=%b", o.hi, o.dn, e.hi, e.dn);
         end
      end
      wait_idle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_oneshot();
      wait_idle();
      test_retrigger();
      test_periodic_abort();
      wait_idle();
      test_ignored();
      wait_idle();
      test_collision();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
